seg_scan_ctrl: RTL

Time-multiplexing scheduler for the four-digit seven-segment display. It shares the single 4-bit nibble decoder path between four digit slots. It holds a staged and an active copy of each digit's nibble, and drives the decoder input and the active-low anode enables. Staged writes are committed to the display only at frame boundaries, so a digit never changes mid-frame. The block sits between the register/host logic and the seven-segment decoder.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_scan_ctrl_if.sv | 20 ++
 rtl/seg_slot_timer.sv | 59 +++++
 rtl/seg_scan_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and helpers for the seven-segment scan controller
package seg_pkg;

   localparam int NDIG = 4;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } seg_state_t;

   // Active-low one-hot anode pattern for a slot index
   function automatic logic [NDIG-1:0] anode_of(input logic [1:0] sel);
      logic [NDIG-1:0] one;
      one = {{(NDIG-1){1'b0}}, 1'b1} << sel;
      return ~one;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - host-side write port and frame status of the scan controller
interface seg_scan_ctrl_if;

   logic       wr_en;
   logic [1:0] wr_addr;
   logic [3:0] wr_data;
   logic       frame_tick;
   logic       upd_ack;

   modport master (
      output wr_en, wr_addr, wr_data,
      input  frame_tick, upd_ack
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      output frame_tick, upd_ack
   );

endinterface

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - BLANK/SHOW slot state machine and slot counter
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int DIV   = 400,
   parameter int BLANK = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   output seg_state_t state,
   output logic       tc,
   output logic       adv
);

   localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   seg_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BLANK;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Terminal count per state; counter clears on every state change
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      tc      = 1'b0;
      case (state_q)
         S_BLANK: begin
            if (cnt_q == CW'(BLANK - 1)) begin
               tc      = 1'b1;
               state_d = S_SHOW;
               cnt_d   = '0;
            end
         end
         S_SHOW: begin
            if (cnt_q == CW'(DIV - 1)) begin
               tc      = 1'b1;
               state_d = S_BLANK;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   assign state = state_q;
   assign adv   = tc && (state_q == S_SHOW);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit time-multiplexed display scheduler with frame-aligned commits
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIV   = 400,
   parameter int BLANK = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   seg_scan_ctrl_if.slave  bus,
   input  logic [NDIG-1:0] dig_en,
   output logic [3:0]      dig_val,
   output logic [1:0]      dig_sel,
   output logic [NDIG-1:0] an
);

   seg_state_t state;
   logic       tc;
   logic       adv;

   logic [NDIG-1:0][3:0] staged_q;
   logic [NDIG-1:0][3:0] active_q;
   logic [NDIG-1:0][3:0] commit_d;
   logic                 pending_q;

   logic       enter_show;
   logic       boundary;
   logic       do_commit;
   logic [1:0] next_sel;

   seg_slot_timer #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .state (state),
      .tc    (tc),
      .adv   (adv)
   );

   assign enter_show = tc && (state == S_BLANK);
   assign boundary   = adv && (dig_sel == 2'd3);
   assign do_commit  = boundary && (pending_q || bus.wr_en);
   assign next_sel   = dig_sel + 2'd1;

   // Staging contents with a same-cycle write merged in, so a boundary write is committed too
   always_comb begin
      commit_d = staged_q;
      if (bus.wr_en) begin
         commit_d[bus.wr_addr] = bus.wr_data;
      end
   end

   // Staging registers, pending flag and frame-aligned active copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         staged_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         if (bus.wr_en) begin
            staged_q <= commit_d;
         end
         if (do_commit) begin
            active_q  <= commit_d;
            pending_q <= 1'b0;
         end else if (bus.wr_en) begin
            pending_q <= 1'b1;
         end
      end
   end

   // Slot index, decoder nibble and anode drive, all registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_sel <= 2'd0;
         dig_val <= 4'd0;
         an      <= '1;
      end else if (adv) begin
         dig_sel <= next_sel;
         dig_val <= do_commit ? commit_d[next_sel] : active_q[next_sel];
         an      <= '1;
      end else if (enter_show) begin
         an      <= dig_en[dig_sel] ? anode_of(dig_sel) : '1;
      end
   end

   // One-cycle frame and commit pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.frame_tick <= 1'b0;
         bus.upd_ack    <= 1'b0;
      end else begin
         bus.frame_tick <= boundary;
         bus.upd_ack    <= do_commit;
      end
   end

endmodule
